// File: rtl/ex_unit_pkg.sv
// Shared constants and latch layouts for the execute stage.
// Op/class encodings must match the decoder that feeds ex_unit.
package ex_unit_pkg;

    localparam int AluOpW   = 8;
    localparam int AluSelW  = 3;
    localparam int RegW     = 32;
    localparam int RegAddrW = 5;

    localparam logic [AluOpW-1:0] EXE_NOP_OP = 8'b0000_0000;
    localparam logic [AluOpW-1:0] EXE_OR     = 8'b0010_0101;
    localparam logic [AluOpW-1:0] EXE_AND    = 8'b0010_0100;
    localparam logic [AluOpW-1:0] EXE_XOR    = 8'b0010_0110;
    localparam logic [AluOpW-1:0] EXE_NOR    = 8'b0010_0111;
    localparam logic [AluOpW-1:0] EXE_SLL    = 8'b0111_1100;
    localparam logic [AluOpW-1:0] EXE_SRL    = 8'b0000_0010;
    localparam logic [AluOpW-1:0] EXE_SRA    = 8'b0000_0011;

    localparam logic [AluSelW-1:0] RES_NOP   = 3'b000;
    localparam logic [AluSelW-1:0] RES_LOGIC = 3'b001;
    localparam logic [AluSelW-1:0] RES_SHIFT = 3'b010;

    localparam logic [RegW-1:0]     ZeroWord   = '0;
    localparam logic [RegAddrW-1:0] NOPRegAddr = '0;

    typedef struct packed {
        logic [AluOpW-1:0]   aluop;
        logic [AluSelW-1:0]  alusel;
        logic [RegW-1:0]     reg1;
        logic [RegW-1:0]     reg2;
        logic [RegAddrW-1:0] wd;
        logic                wreg;
    } id_ex_t;

    // Writeback triple shared by the EX forwarding path and the EX/MEM latch.
    typedef struct packed {
        logic                wreg;
        logic [RegAddrW-1:0] wd;
        logic [RegW-1:0]     wdata;
    } wb_t;

    localparam id_ex_t IdExBubble = '0;
    localparam wb_t    WbBubble   = '0;

endpackage

// File: rtl/ex_unit_if.sv
// Decode-to-execute bundle plus the forwarding outputs that return to decode.
interface ex_unit_if
    import ex_unit_pkg::*;
    ();

    logic                stall_i;
    logic                flush_i;
    logic [AluOpW-1:0]   aluop_i;
    logic [AluSelW-1:0]  alusel_i;
    logic [RegW-1:0]     reg1_i;
    logic [RegW-1:0]     reg2_i;
    logic [RegAddrW-1:0] wd_i;
    logic                wreg_i;

    logic                ex_wreg_o;
    logic [RegAddrW-1:0] ex_wd_o;
    logic [RegW-1:0]     ex_wdata_o;
    logic                mem_wreg_o;
    logic [RegAddrW-1:0] mem_wd_o;
    logic [RegW-1:0]     mem_wdata_o;

    modport master (
        output stall_i, flush_i, aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i,
        input  ex_wreg_o, ex_wd_o, ex_wdata_o, mem_wreg_o, mem_wd_o, mem_wdata_o
    );

    modport slave (
        input  stall_i, flush_i, aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i,
        output ex_wreg_o, ex_wd_o, ex_wdata_o, mem_wreg_o, mem_wd_o, mem_wdata_o
    );

endinterface

// File: rtl/ex_alu.sv
// Combinational logic/shift unit sitting between the ID/EX and EX/MEM latches.
// Unknown ops or classes produce zero so a bubble always yields ZeroWord.
module ex_alu
    import ex_unit_pkg::*;
(
    input  logic [AluOpW-1:0]  op,
    input  logic [AluSelW-1:0] sel,
    input  logic [RegW-1:0]    r1,
    input  logic [RegW-1:0]    r2,
    output logic [RegW-1:0]    result
);

    logic [4:0] sa;

    assign sa = r1[4:0];

    always_comb begin
        result = ZeroWord;
        case (sel)
            RES_LOGIC: begin
                case (op)
                    EXE_OR:  result = r1 | r2;
                    EXE_AND: result = r1 & r2;
                    EXE_XOR: result = r1 ^ r2;
                    EXE_NOR: result = ~(r1 | r2);
                    default: result = ZeroWord;
                endcase
            end
            RES_SHIFT: begin
                case (op)
                    EXE_SLL: result = r2 << sa;
                    EXE_SRL: result = r2 >> sa;
                    EXE_SRA: result = $unsigned($signed(r2) >>> sa);
                    default: result = ZeroWord;
                endcase
            end
            default: result = ZeroWord;
        endcase
    end

endmodule

// File: rtl/ex_unit.sv
// Execute stage: ID/EX latch, ALU, EX/MEM latch. ex_* feed decode forwarding
// straight from the ID/EX latch; mem_* are the registered copy one edge later.
module ex_unit
    import ex_unit_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    ex_unit_if.slave   bus
);

    id_ex_t           id_ex;
    wb_t              ex_wb;
    wb_t              mem_wb;
    logic [RegW-1:0]  alu_result;

    // A stall turns into a bubble here; the decoder re-presents the held op.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            id_ex <= IdExBubble;
        end else if (bus.flush_i || bus.stall_i) begin
            id_ex <= IdExBubble;
        end else begin
            id_ex <= '{aluop:  bus.aluop_i,
                       alusel: bus.alusel_i,
                       reg1:   bus.reg1_i,
                       reg2:   bus.reg2_i,
                       wd:     bus.wd_i,
                       wreg:   bus.wreg_i};
        end
    end

    ex_alu u_alu (
        .op     (id_ex.aluop),
        .sel    (id_ex.alusel),
        .r1     (id_ex.reg1),
        .r2     (id_ex.reg2),
        .result (alu_result)
    );

    always_comb begin
        ex_wb       = WbBubble;
        ex_wb.wreg  = id_ex.wreg;
        ex_wb.wd    = id_ex.wd;
        ex_wb.wdata = alu_result;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_wb <= WbBubble;
        end else if (bus.flush_i) begin
            mem_wb <= WbBubble;
        end else begin
            mem_wb <= ex_wb;
        end
    end

    assign bus.ex_wreg_o   = ex_wb.wreg;
    assign bus.ex_wd_o     = ex_wb.wd;
    assign bus.ex_wdata_o  = ex_wb.wdata;
    assign bus.mem_wreg_o  = mem_wb.wreg;
    assign bus.mem_wd_o    = mem_wb.wd;
    assign bus.mem_wdata_o = mem_wb.wdata;

endmodule

// File: tb/tb_ex_unit.sv
// Randomised bench for ex_unit: directed cases with literal expectations plus
// a cycle-level reference model compared on every falling edge.
module tb_ex_unit;
    import ex_unit_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    ex_unit_if bus ();

    ex_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Reference state: what ex_* and mem_* must show.
    logic        m_ex_wreg    = 1'b0;
    logic [4:0]  m_ex_wd      = '0;
    logic [31:0] m_ex_wdata   = '0;
    logic        m_mem_wreg   = 1'b0;
    logic [4:0]  m_mem_wd     = '0;
    logic [31:0] m_mem_wdata  = '0;

    function automatic logic [31:0] modelResult(input logic [7:0] op, input logic [2:0] sel,
                                                input logic [31:0] r1, input logic [31:0] r2);
        logic [31:0] v;
        int          n;
        v = r2;
        n = int'(r1[4:0]);
        if (sel == 3'b001) begin
            if (op == 8'b00100101)      return r1 | r2;
            else if (op == 8'b00100100) return r1 & r2;
            else if (op == 8'b00100110) return r1 ^ r2;
            else if (op == 8'b00100111) return ~(r1 | r2);
            return 32'h0;
        end
        if (sel == 3'b010) begin
            if (op == 8'b01111100) begin
                for (int i = 0; i < n; i++) v = {v[30:0], 1'b0};
                return v;
            end
            if (op == 8'b00000010) begin
                for (int i = 0; i < n; i++) v = {1'b0, v[31:1]};
                return v;
            end
            if (op == 8'b00000011) begin
                for (int i = 0; i < n; i++) v = {v[31], v[31:1]};
                return v;
            end
            return 32'h0;
        end
        return 32'h0;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_ex_wreg   <= 1'b0;  m_ex_wd  <= '0; m_ex_wdata  <= '0;
            m_mem_wreg  <= 1'b0;  m_mem_wd <= '0; m_mem_wdata <= '0;
        end else begin
            if (bus.flush_i) begin
                m_mem_wreg <= 1'b0; m_mem_wd <= '0; m_mem_wdata <= '0;
            end else begin
                m_mem_wreg <= m_ex_wreg; m_mem_wd <= m_ex_wd; m_mem_wdata <= m_ex_wdata;
            end
            if (bus.flush_i || bus.stall_i) begin
                m_ex_wreg <= 1'b0; m_ex_wd <= '0; m_ex_wdata <= '0;
            end else begin
                m_ex_wreg  <= bus.wreg_i;
                m_ex_wd    <= bus.wd_i;
                m_ex_wdata <= modelResult(bus.aluop_i, bus.alusel_i, bus.reg1_i, bus.reg2_i);
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        checkOutput("model ex_wreg",    {31'b0, bus.ex_wreg_o},  {31'b0, m_ex_wreg});
        checkOutput("model ex_wd",      {27'b0, bus.ex_wd_o},    {27'b0, m_ex_wd});
        checkOutput("model ex_wdata",   bus.ex_wdata_o,          m_ex_wdata);
        checkOutput("model mem_wreg",   {31'b0, bus.mem_wreg_o}, {31'b0, m_mem_wreg});
        checkOutput("model mem_wd",     {27'b0, bus.mem_wd_o},   {27'b0, m_mem_wd});
        checkOutput("model mem_wdata",  bus.mem_wdata_o,         m_mem_wdata);
    end

    // Drive one cycle of inputs, then return 1 time unit after the capturing edge.
    task automatic applyStimulus(input logic [7:0] op, input logic [2:0] sel,
                                 input logic [31:0] r1, input logic [31:0] r2,
                                 input logic [4:0] wd, input logic wreg,
                                 input logic stall, input logic flush);
        bus.aluop_i  = op;
        bus.alusel_i = sel;
        bus.reg1_i   = r1;
        bus.reg2_i   = r2;
        bus.wd_i     = wd;
        bus.wreg_i   = wreg;
        bus.stall_i  = stall;
        bus.flush_i  = flush;
        @(posedge clk);
        #1;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " ex_wreg"},   {31'b0, bus.ex_wreg_o},  32'h0);
        checkOutput({tag, " ex_wd"},     {27'b0, bus.ex_wd_o},    32'h0);
        checkOutput({tag, " ex_wdata"},  bus.ex_wdata_o,          32'h0);
        checkOutput({tag, " mem_wreg"},  {31'b0, bus.mem_wreg_o}, 32'h0);
        checkOutput({tag, " mem_wd"},    {27'b0, bus.mem_wd_o},   32'h0);
        checkOutput({tag, " mem_wdata"}, bus.mem_wdata_o,         32'h0);
    endtask

    logic [7:0] op_list [8];

    initial begin
        logic [7:0] op;
        logic [2:0] sel;
        int         pick;

        op_list = '{8'b00100101, 8'b00100100, 8'b00100110, 8'b00100111,
                    8'b01111100, 8'b00000010, 8'b00000011, 8'h55};
        bus.aluop_i = '0; bus.alusel_i = '0; bus.reg1_i = '0; bus.reg2_i = '0;
        bus.wd_i = '0; bus.wreg_i = 1'b0; bus.stall_i = 1'b0; bus.flush_i = 1'b0;

        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkAllZero("reset");
        rst = 1'b1;

        // OR then its EX/MEM copy one edge later.
        applyStimulus(8'b00100101, 3'b001, 32'h00001100, 32'h00000020, 5'd5, 1'b1, 1'b0, 1'b0);
        checkOutput("or ex_wdata", bus.ex_wdata_o, 32'h00001120);
        checkOutput("or ex_wd",    {27'b0, bus.ex_wd_o}, 32'd5);
        applyStimulus(8'h00, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("or mem_wdata", bus.mem_wdata_o, 32'h00001120);
        checkOutput("nop ex_wdata", bus.ex_wdata_o, 32'h0);

        applyStimulus(8'b00000011, 3'b010, 32'd4, 32'h80000000, 5'd1, 1'b1, 1'b0, 1'b0);
        checkOutput("sra ex_wdata", bus.ex_wdata_o, 32'hF8000000);
        applyStimulus(8'b00000010, 3'b010, 32'd4, 32'h80000000, 5'd1, 1'b1, 1'b0, 1'b0);
        checkOutput("srl ex_wdata", bus.ex_wdata_o, 32'h08000000);
        applyStimulus(8'b01111100, 3'b010, 32'd31, 32'h00000001, 5'd1, 1'b1, 1'b0, 1'b0);
        checkOutput("sll ex_wdata", bus.ex_wdata_o, 32'h80000000);
        applyStimulus(8'b00000011, 3'b010, 32'd0, 32'h80000001, 5'd1, 1'b1, 1'b0, 1'b0);
        checkOutput("sra0 ex_wdata", bus.ex_wdata_o, 32'h80000001);
        applyStimulus(8'b00100111, 3'b001, 32'h0, 32'h0, 5'd2, 1'b1, 1'b0, 1'b0);
        checkOutput("nor ex_wdata", bus.ex_wdata_o, 32'hFFFFFFFF);
        applyStimulus(8'h55, 3'b001, 32'h1234, 32'h5678, 5'd9, 1'b1, 1'b0, 1'b0);
        checkOutput("badop ex_wdata", bus.ex_wdata_o, 32'h0);
        checkOutput("badop ex_wreg",  {31'b0, bus.ex_wreg_o}, 32'd1);

        // Back-to-back dependent pair.
        applyStimulus(8'b00100101, 3'b001, 32'h000000A0, 32'h0000000F, 5'd3, 1'b1, 1'b0, 1'b0);
        checkOutput("fwd ex_wdata",  bus.ex_wdata_o, 32'h000000AF);
        checkOutput("fwd prior mem_wd", {27'b0, bus.mem_wd_o}, 32'd9);
        applyStimulus(8'b00100100, 3'b001, 32'h000000AF, 32'h0000000C, 5'd4, 1'b1, 1'b0, 1'b0);
        checkOutput("fwd mem_wd",    {27'b0, bus.mem_wd_o}, 32'd3);
        checkOutput("fwd mem_wdata", bus.mem_wdata_o, 32'h000000AF);
        checkOutput("and ex_wdata",  bus.ex_wdata_o, 32'h0000000C);

        // Two stall cycles inject two bubbles; the held XOR enters afterwards.
        applyStimulus(8'b00100110, 3'b001, 32'hFF00FF00, 32'h0F0F0F0F, 5'd7, 1'b1, 1'b0, 1'b0);
        checkOutput("xor ex_wdata", bus.ex_wdata_o, 32'hF00FF00F);
        applyStimulus(8'b00100110, 3'b001, 32'hFF00FF00, 32'h0F0F0F0F, 5'd7, 1'b1, 1'b1, 1'b0);
        checkOutput("stall1 ex_wreg",    {31'b0, bus.ex_wreg_o}, 32'd0);
        checkOutput("stall1 ex_wdata",   bus.ex_wdata_o, 32'h0);
        checkOutput("stall1 mem_wdata",  bus.mem_wdata_o, 32'hF00FF00F);
        checkOutput("stall1 mem_wd",     {27'b0, bus.mem_wd_o}, 32'd7);
        applyStimulus(8'b00100110, 3'b001, 32'hFF00FF00, 32'h0F0F0F0F, 5'd7, 1'b1, 1'b1, 1'b0);
        checkOutput("stall2 ex_wreg",    {31'b0, bus.ex_wreg_o}, 32'd0);
        checkOutput("stall2 mem_wreg",   {31'b0, bus.mem_wreg_o}, 32'd0);
        applyStimulus(8'b00100110, 3'b001, 32'hFF00FF00, 32'h0F0F0F0F, 5'd7, 1'b1, 1'b0, 1'b0);
        checkOutput("resume ex_wdata",   bus.ex_wdata_o, 32'hF00FF00F);
        checkOutput("resume ex_wd",      {27'b0, bus.ex_wd_o}, 32'd7);

        // Flush together with stall while both latches hold live results.
        applyStimulus(8'b00100101, 3'b001, 32'h1, 32'h2, 5'd8, 1'b1, 1'b0, 1'b0);
        applyStimulus(8'b00100101, 3'b001, 32'h1, 32'h2, 5'd8, 1'b1, 1'b1, 1'b1);
        checkAllZero("flush");
        applyStimulus(8'b00100101, 3'b001, 32'h1, 32'h2, 5'd8, 1'b1, 1'b1, 1'b0);
        checkOutput("post-flush stall ex_wreg", {31'b0, bus.ex_wreg_o}, 32'd0);

        // Asynchronous reset between edges with both latches full.
        applyStimulus(8'b00100101, 3'b001, 32'h10, 32'h01, 5'd6, 1'b1, 1'b0, 1'b0);
        applyStimulus(8'b00100101, 3'b001, 32'h20, 32'h02, 5'd6, 1'b1, 1'b0, 1'b0);
        #2 rst = 1'b0;
        #1;
        checkAllZero("async reset");
        @(posedge clk);
        #1 rst = 1'b1;

        // Randomised traffic checked by the model on every falling edge.
        for (int n = 0; n < 400; n++) begin
            pick = $urandom_range(0, 9);
            if (pick < 4)      sel = 3'b001;
            else if (pick < 8) sel = 3'b010;
            else               sel = 3'($urandom_range(0, 7));
            op = ($urandom_range(0, 7) == 0) ? 8'($urandom) : op_list[$urandom_range(0, 7)];
            applyStimulus(op, sel, $urandom, $urandom, 5'($urandom), 1'($urandom),
                          ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) == 0));
        end

        applyStimulus(8'h00, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
        applyStimulus(8'h00, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ex_unit.md
# ex_unit

Execute-side consumer of the decode bundle: latches decoder outputs into an ID/EX register, computes logic and shift results, presents the EX-stage writeback triple combinationally for decode-stage forwarding, and registers it into an EX/MEM latch. It sits between the decoder and the memory stage. Its `ex_*` and `mem_*` outputs close the forwarding loop back into decode.

## Interface
Parameters (shared-package constants, not overridable):
- `AluOpW`, 8, ALU operation code width
- `AluSelW`, 3, result-class select width

Ports:
- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `stall_i`  in  1  upstream (IF/ID) stall; EX side keeps running
- `flush_i`  in  1  discard everything in flight
- `aluop_i`  in  8  decoded ALU op
- `alusel_i`  in  3  decoded result class
- `reg1_i`  in  32  operand 1 (register value or shift amount)
- `reg2_i`  in  32  operand 2
- `wd_i`  in  5  destination register
- `wreg_i`  in  1  write enable
- `ex_wreg_o`  out  1  EX-stage write enable (combinational from ID/EX latch)
- `ex_wd_o`  out  5  EX-stage destination
- `ex_wdata_o`  out  32  EX-stage result
- `mem_wreg_o`  out  1  EX/MEM latched write enable
- `mem_wd_o`  out  5  EX/MEM latched destination
- `mem_wdata_o`  out  32  EX/MEM latched result

## Operation
- ID/EX latch holds {aluop, alusel, reg1, reg2, wd, wreg}. A bubble is all-zero: NOP op, NOP class, wd=0, wreg=0, operands 0.
- Per rising edge, ID/EX latch:
  - flush_i=1: load bubble.
  - else stall_i=1: load bubble (decoder output is held upstream and re-presented).
  - else: load inputs.
- EX/MEM latch, per rising edge:
  - flush_i=1: clear to bubble.
  - else: load {ex_wreg_o, ex_wd_o, ex_wdata_o}.
- flush_i has priority over stall_i when both are asserted.
- Logic class (alusel=001), with op codes:
  - OR 00100101: r1|r2
  - AND 00100100: r1&r2
  - XOR 00100110: r1^r2
  - NOR 00100111: ~(r1|r2)
  - any other op: 0
- Shift class (alusel=010), shift amount = r1[4:0], value = r2:
  - SLL 01111100: r2<<sa
  - SRL 00000010: logical right
  - SRA 00000011: arithmetic right, sign bit replicated for sa in 0..31; sa=0 passes r2
  - any other op: 0
- NOP class or undefined alusel: ex_wdata_o=0.
- ex_wreg_o and ex_wd_o pass through from the latch unchanged.
- wd=0 with wreg=1 is forwarded as-is; the register file ignores writes to $0.

## Timing
- Reset values: both latches clear to bubble, so every output is 0 while rst=0. Reset is asynchronous on assertion; deassertion is sampled by clk.
- Latency:
  - Input sampled at edge N drives ex_* in cycle N→N+1.
  - It appears on mem_* after edge N+1.
- ex_* are combinational from registered state only. There is no combinational path from any `_i` port to any output.
- Stall for k cycles inserts k bubbles into EX. The held instruction enters on the first edge with stall_i=0.
- Flush mid-stall clears both latches on that edge. Subsequent stalled edges keep loading bubbles.
- Reset asserted mid-operation drops all in-flight results immediately. No partial writeback reaches mem_*.

## Structure
- Shared package holds:
  - op codes: EXE_OR/AND/XOR/NOR/SLL/SRL/SRA/NOP_OP
  - class codes: RES_LOGIC=001, RES_SHIFT=010, RES_NOP=000
  - bus widths
  - ZeroWord, NOPRegAddr
- One sub-module: `ex_alu`, purely combinational (op, sel, r1, r2 → result). It is instantiated between the two latches. The latches and stall/flush control stay in `ex_unit`.

## Test plan
- Reset then OR (aluop=00100101, sel=001, reg1=0x00001100, reg2=0x00000020, wd=5, wreg=1) → next cycle ex_wdata_o=0x00001120, ex_wd_o=5. One cycle later mem_wdata_o=0x00001120.
- SRA reg1=4, reg2=0x80000000 → 0xF8000000. SRL same operands → 0x08000000. SLL reg1=31, reg2=1 → 0x80000000.
- NOR reg1=reg2=0 → 0xFFFFFFFF. Unknown op 0x55 with sel=001 → 0, with wreg still passed through.
- Back-to-back OR to wd=3 then AND reading wd=3: ex_* shows OR result while mem_* shows the prior instruction. Next cycle mem_wd_o=3 and mem_wdata_o equals the OR result.
- stall_i=1 for 2 cycles during a valid stream → exactly 2 bubbles (ex_wreg_o=0, ex_wdata_o=0). The EX/MEM latch keeps advancing: the pre-stall result reaches mem_* on schedule.
- flush_i and stall_i high together with both latches full → after the edge all six outputs are 0. Asserting rst asynchronously between edges zeroes all outputs immediately.
